// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: holds the PC, drives the asynchronous instruction ROM address
// straight from it and captures the returned word into an IF/ID register with
// a valid/ready handshake toward decode. Handles redirects, fetch halt and a
// count of instructions loaded into IF/ID.
//
// Optional build macro FETCH_MISALIGN_TRAP_EN: when defined, a redirect whose
// target is not word aligned raises a sticky misalign_trap and halts fetch.
// When undefined, the low two target bits are dropped and the trap stays 0.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [31:0] fetch_count,
   output logic        misalign_trap
);

   // Architectural state
   logic [31:0] pc_r;
   logic        id_valid_r;
   logic [31:0] id_instr_r;
   logic [31:0] id_pc_r;
   logic [31:0] id_pc_plus4_r;
   logic [31:0] fetch_count_r;
   logic        trap_r;

   // Next-state values
   logic [31:0] pc_nxt_s;
   logic        id_valid_nxt_s;
   logic [31:0] id_instr_nxt_s;
   logic [31:0] id_pc_nxt_s;
   logic [31:0] id_pc_plus4_nxt_s;
   logic [31:0] fetch_count_nxt_s;
   logic        trap_nxt_s;

   logic [31:0] redirect_pc_s;
   logic        misalign_s;
   logic [31:0] pc_plus4_s;
   logic        advance_s;

`ifdef FETCH_MISALIGN_TRAP_EN
   // Misaligned targets are loaded as-is and flagged
   assign redirect_pc_s = redirect_target;
   assign misalign_s    = (redirect_target[1:0] != 2'b00);
`else
   // Low target bits are ignored so the PC always stays word aligned
   assign redirect_pc_s = redirect_target & 32'hFFFF_FFFC;
   assign misalign_s    = 1'b0;
`endif

   assign pc_plus4_s = pc_r + 32'd4;
   // A new word may be loaded when enabled, not trapped and IF/ID is free or draining
   assign advance_s  = fetch_en & ~trap_r & (~id_valid_r | id_ready);

   // Next-state selection: redirect > advance > consume-only > stall
   always_comb begin
      pc_nxt_s          = pc_r;
      id_valid_nxt_s    = id_valid_r;
      id_instr_nxt_s    = id_instr_r;
      id_pc_nxt_s       = id_pc_r;
      id_pc_plus4_nxt_s = id_pc_plus4_r;
      fetch_count_nxt_s = fetch_count_r;
      trap_nxt_s        = trap_r;
      if (redirect_valid) begin
         pc_nxt_s       = redirect_pc_s;
         id_valid_nxt_s = 1'b0;
         id_instr_nxt_s = NOP_INSTR;
         trap_nxt_s     = trap_r | misalign_s;
      end else if (advance_s) begin
         pc_nxt_s          = pc_plus4_s;
         id_valid_nxt_s    = 1'b1;
         id_instr_nxt_s    = imem_data;
         id_pc_nxt_s       = pc_r;
         id_pc_plus4_nxt_s = pc_plus4_s;
         fetch_count_nxt_s = fetch_count_r + 32'd1;
      end else if (id_valid_r && id_ready) begin
         id_valid_nxt_s = 1'b0;
         id_instr_nxt_s = NOP_INSTR;
      end else begin
         pc_nxt_s = pc_r;
      end
   end

   // State register with synchronous reset overriding every other input
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r          <= RESET_PC;
         id_valid_r    <= 1'b0;
         id_instr_r    <= NOP_INSTR;
         id_pc_r       <= 32'h0000_0000;
         id_pc_plus4_r <= 32'h0000_0000;
         fetch_count_r <= 32'h0000_0000;
         trap_r        <= 1'b0;
      end else begin
         pc_r          <= pc_nxt_s;
         id_valid_r    <= id_valid_nxt_s;
         id_instr_r    <= id_instr_nxt_s;
         id_pc_r       <= id_pc_nxt_s;
         id_pc_plus4_r <= id_pc_plus4_nxt_s;
         fetch_count_r <= fetch_count_nxt_s;
         trap_r        <= trap_nxt_s;
      end
   end

   assign imem_addr     = pc_r;
   assign id_valid      = id_valid_r;
   assign id_instr      = id_instr_r;
   assign id_pc         = id_pc_r;
   assign id_pc_plus4   = id_pc_plus4_r;
   assign fetch_count   = fetch_count_r;
   assign misalign_trap = trap_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Table of per-cycle vectors for the directed fetch scenarios, a reset-vs-
// redirect sequence, and a randomized-backpressure phase whose expected
// instruction stream is queued when the redirect is issued and popped on each
// IF/ID transfer. Honours FETCH_MISALIGN_TRAP_EN for the misaligned rows.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] W0  = 32'h0052_0333;
   localparam logic [31:0] W1  = 32'h4021_84b3;
   localparam logic [31:0] W2  = 32'h0060_2503;
   localparam logic [31:0] W3  = 32'h00a0_2583;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] fetch_count;
   logic        misalign_trap;

   logic [31:0] rom [0:63];

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   assign imem_data = rom[imem_addr[7:2]];

   instr_fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .fetch_en        (fetch_en),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_instr        (id_instr),
      .id_pc           (id_pc),
      .id_pc_plus4     (id_pc_plus4),
      .fetch_count     (fetch_count),
      .misalign_trap   (misalign_trap)
   );

   function automatic logic [31:0] rom_word(input int i);
      case (i)
         0:       rom_word = W0;
         1:       rom_word = W1;
         2:       rom_word = W2;
         3:       rom_word = W3;
         default: rom_word = 32'hC0DE_0000 + 32'(i);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct packed {
      logic        fe;
      logic        rdy;
      logic        rv;
      logic [31:0] tgt;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [31:0] e_addr;
      logic [31:0] e_cnt;
      logic        e_trap;
   } vec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   localparam int NV = 18;
   vec_t vecs [NV];
   exp_t sb [$];

   initial begin
      exp_t        e;
      logic [31:0] hold_pc;
      logic [31:0] hold_instr;
      logic        stall_pend;
      int          cyc;

      for (int i = 0; i < 64; i++) rom[i] = rom_word(i);

      // fe rdy rv tgt | valid id_pc instr addr count trap
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,  W0,  32'h4,  32'd1, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4,  W1,  32'h8,  32'd2, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4,  W1,  32'h8,  32'd2, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4,  W1,  32'h8,  32'd2, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4,  W1,  32'h8,  32'd2, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8,  W2,  32'hC,  32'd3, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC,  W3,  32'h10, 32'd4, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'hC, NOP, 32'h20, 32'd4, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, rom_word(8), 32'h24, 32'd5, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h20, NOP, 32'h24, 32'd5, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h20, NOP, 32'h24, 32'd5, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h24, rom_word(9), 32'h28, 32'd6, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h24, NOP, 32'hFFFF_FFFC, 32'd6, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, rom_word(63), 32'h0, 32'd7, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, W0, 32'h4, 32'd8, 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
      vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 32'h0, NOP, 32'h22, 32'd8, 1'b1};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, NOP, 32'h22, 32'd8, 1'b1};
      vecs[17] = '{1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, NOP, 32'h40, 32'd8, 1'b1};
`else
      vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 32'h0, NOP, 32'h20, 32'd8, 1'b0};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h20, rom_word(8), 32'h24, 32'd9, 1'b0};
      vecs[17] = '{1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h20, NOP, 32'h40, 32'd9, 1'b0};
`endif

      // Reset for two cycles
      reset           = 1'b1;
      fetch_en        = 1'b0;
      id_ready        = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_instr", id_instr, NOP);
      chk("rst_pc", id_pc, 32'h0);
      chk("rst_pc4", id_pc_plus4, 32'h0);
      chk("rst_cnt", fetch_count, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_trap", 32'(misalign_trap), 32'd0);

      // Directed vector table
      for (int i = 0; i < NV; i++) begin
         fetch_en        = vecs[i].fe;
         id_ready        = vecs[i].rdy;
         redirect_valid  = vecs[i].rv;
         redirect_target = vecs[i].tgt;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
         chk($sformatf("v%0d_pc", i), id_pc, vecs[i].e_pc);
         chk($sformatf("v%0d_pc4", i), id_pc_plus4, vecs[i].e_pc + 32'd4);
         chk($sformatf("v%0d_instr", i), id_instr, vecs[i].e_instr);
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_cnt", i), fetch_count, vecs[i].e_cnt);
         chk($sformatf("v%0d_trap", i), 32'(misalign_trap), 32'(vecs[i].e_trap));
      end

      // Reset wins over a simultaneous redirect (and clears a sticky trap)
      reset           = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h80;
      @(posedge clk);
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      fetch_en       = 1'b0;
      chk("rr_addr", imem_addr, 32'h0);
      chk("rr_valid", 32'(id_valid), 32'd0);
      chk("rr_cnt", fetch_count, 32'd0);
      chk("rr_trap", 32'(misalign_trap), 32'd0);

      // Random backpressure: expected stream queued with the redirect
      redirect_valid  = 1'b1;
      redirect_target = 32'h40;
      fetch_en        = 1'b1;
      id_ready        = 1'b0;
      for (int k = 0; k < 24; k++) sb.push_back('{32'h40 + 32'(4 * k), rom_word(16 + k)});
      @(posedge clk);
      @(negedge clk);
      redirect_valid = 1'b0;
      stall_pend = 1'b0;
      hold_pc    = 32'h0;
      hold_instr = 32'h0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 400) begin
         if (stall_pend) begin
            chk("stall_valid", 32'(id_valid), 32'd1);
            chk("stall_pc", id_pc, hold_pc);
            chk("stall_instr", id_instr, hold_instr);
            stall_pend = 1'b0;
         end
         fetch_en = ($urandom_range(0, 3) != 0);
         id_ready = ($urandom_range(0, 2) != 0);
         if (id_valid && id_ready) begin
            e = sb.pop_front();
            chk("sb_pc", id_pc, e.pc);
            chk("sb_instr", id_instr, e.instr);
            chk("sb_pc4", id_pc_plus4, e.pc + 32'd4);
         end else if (id_valid) begin
            hold_pc    = id_pc;
            hold_instr = id_instr;
            stall_pend = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL sb_timeout: %0d transfers outstanding, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage feeding the word-addressed, asynchronous-read instruction ROM and the decoder.
- Holds the program counter (PC) and drives the ROM address combinationally from it.
- Captures the returned instruction into an IF/ID register, with a valid/ready handshake toward decode.
- Handles branch/jump redirects, fetch halt and a fetched-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on id_instr when the stage is empty or flushed (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- fetch_en  input  1  1 = fetching allowed; 0 = no new fetch, PC holds
- imem_addr  output  32  byte address to instruction ROM; equals PC register
- imem_data  input  32  instruction word returned combinationally by ROM for imem_addr
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_target  input  32  new PC for the redirect
- id_valid  output  1  IF/ID register holds a valid instruction
- id_ready  input  1  decoder accepts the IF/ID contents this cycle
- id_instr  output  32  fetched instruction
- id_pc  output  32  PC of id_instr
- id_pc_plus4  output  32  id_pc + 4
- fetch_count  output  32  number of instructions loaded into IF/ID since reset
- misalign_trap  output  1  misaligned redirect detected (see Optional Feature)

Behaviour:
- Reset is synchronous: on a rising clk edge with reset=1:
  - pc = RESET_PC, id_valid = 0, id_instr = NOP_INSTR, id_pc = 0, id_pc_plus4 = 0, fetch_count = 0, misalign_trap = 0.
  - Reset overrides every other input, including a redirect arriving in the same cycle.
- imem_addr = pc, purely combinational. No ROM latency: imem_data is valid in the same cycle.
- Internal signal advance = fetch_en & ~misalign_trap & (~id_valid | id_ready).
- Per-cycle priority:
  1. redirect_valid=1: pc <= target; id_valid <= 0; id_instr <= NOP_INSTR; the instruction at the old pc is discarded; fetch_count unchanged. Redirect wins over stall and over advance.
  2. else advance=1: id_instr <= imem_data; id_pc <= pc; id_pc_plus4 <= pc+4; id_valid <= 1; pc <= pc+4; fetch_count <= fetch_count+1.
  3. else id_valid=1 & id_ready=1 (consumed, but fetch_en=0): id_valid <= 0; id_instr <= NOP_INSTR; pc holds.
  4. else (stall: id_valid=1 & id_ready=0): all state holds; id_* stable until accepted.
- Latency: an instruction at PC p appears on id_* one cycle after pc=p. Sustained throughput is 1 instruction/cycle while id_ready=1.
- Handshake rule: a transfer occurs on any cycle with id_valid & id_ready. Once id_valid is asserted, id_* must not change until the transfer or a redirect.
- Arithmetic: pc+4 and fetch_count both wrap modulo 2^32 (32'hFFFF_FFFC -> 0; 32'hFFFF_FFFF -> 0). There is no address-range check; PC beyond the ROM size is fetched as-is.
- fetch_en=0 with id_valid=1 and id_ready=0: stall continues; no state changes.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_target[1:0] != 0 sets misalign_trap=1 (sticky until reset).
  - pc is loaded with the target anyway, id_valid <= 0, and advance is forced to 0, so fetch halts.
  - A later aligned redirect does not clear the trap.
- Undefined:
  - redirect_target[1:0] is ignored; pc <= {target[31:2], 2'b00}.
  - misalign_trap is tied to 0.

Test Plan:
- Reset and linear fetch: reset 2 cycles, RESET_PC=0, ROM words 0..3 = 0x00520333, 0x402184b3, 0x00602503, 0x00a02583, id_ready=1 -> id_valid rises cycle 1; id_pc 0,4,8,12 on consecutive cycles; id_instr matches; fetch_count=4 after 4 fetches.
- Backpressure: id_ready=0 for 3 cycles while id_instr=0x402184b3 at id_pc=4 -> id_* and pc=8 hold; fetch_count holds; after id_ready=1, next cycle id_pc=8.
- Redirect during stall: id_valid=1, id_ready=0, redirect_valid=1, target=0x20 -> next cycle id_valid=0, id_instr=0x00000013, imem_addr=0x20; the following cycle id_pc=0x20.
- Fetch halt: fetch_en=0 with id_ready=1 -> id_valid drops after one transfer; pc frozen; re-enable resumes at the frozen pc.
- Wrap: redirect to 0xFFFFFFFC, one fetch -> id_pc_plus4=0, imem_addr=0.
- Misaligned redirect target 0x22:
  - With FETCH_MISALIGN_TRAP_EN: misalign_trap=1, id_valid stays 0, fetch_count frozen.
  - Without it: imem_addr=0x20, fetching continues.
